// File: rtl/or16_result_stage_if.sv
// Handshake bundle between the OR16 datapath, the result stage and its consumer.
// The acc_en select exists only when OR16_STAGE_ACCUM_EN is defined.
interface or16_result_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
`ifdef OR16_STAGE_ACCUM_EN
   logic        acc_en;
`endif
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_zr;
   logic        out_ng;

   modport master (
`ifdef OR16_STAGE_ACCUM_EN
      output acc_en,
`endif
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_zr, out_ng
   );

   modport slave (
`ifdef OR16_STAGE_ACCUM_EN
      input  acc_en,
`endif
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_zr, out_ng
   );
endinterface

// File: rtl/or16_result_stage.sv
// Registered OR16 result stage: 2-entry skid buffer with zero/negative flags.
// Define OR16_STAGE_ACCUM_EN to add the acc_en input and OR-accumulator.
module or16_result_stage (
   input logic                clk,
   input logic                reset,
   or16_result_stage_if.slave bus
);
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] main_q, main_d;
   logic [15:0] skid_q, skid_d;
   logic        zr_q, zr_d;
   logic        ng_q, ng_d;
   logic        in_ready_q, in_ready_d;
   logic        load_main;
   logic        accept;
   logic        deliver;
   logic [15:0] word;

   assign accept  = bus.in_valid && in_ready_q;
   assign deliver = (state_q != EMPTY) && bus.out_ready;

`ifdef OR16_STAGE_ACCUM_EN
   logic [15:0] acc_q, acc_d;

   assign word = bus.acc_en ? (bus.in_data | acc_q) : bus.in_data;

   always_comb begin
      acc_d = acc_q;
      if (accept) begin
         acc_d = word;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= 16'h0000;
      end else begin
         acc_q <= acc_d;
      end
   end
`else
   assign word = bus.in_data;
`endif

   always_comb begin
      state_d   = state_q;
      main_d    = main_q;
      skid_d    = skid_q;
      load_main = 1'b0;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d   = ONE;
               main_d    = word;
               load_main = 1'b1;
            end
         end
         ONE: begin
            if (accept && deliver) begin
               main_d    = word;
               load_main = 1'b1;
            end else if (accept) begin
               state_d = FULL;
               skid_d  = word;
            end else if (deliver) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // in_ready is low here, so only a delivery can change anything
            if (deliver) begin
               state_d   = ONE;
               main_d    = skid_q;
               load_main = 1'b1;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase

      zr_d       = load_main ? (main_d == 16'h0000) : zr_q;
      ng_d       = load_main ? main_d[15] : ng_q;
      in_ready_d = (state_d != FULL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= EMPTY;
         main_q     <= 16'h0000;
         skid_q     <= 16'h0000;
         zr_q       <= 1'b0;
         ng_q       <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         zr_q       <= zr_d;
         ng_q       <= ng_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = (state_q != EMPTY);
   assign bus.out_data  = main_q;
   assign bus.out_zr    = zr_q;
   assign bus.out_ng    = ng_q;
endmodule

// File: tb/tb_or16_result_stage.sv
// Directed and random checks of or16_result_stage against a FIFO model.
// Accumulate vectors run only when OR16_STAGE_ACCUM_EN is defined.
module tb_or16_result_stage;
   logic clk;
   logic reset;
   int   assert_cnt;
   int   fail_cnt;

   or16_result_stage_if bus ();

   or16_result_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      assert_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [15:0] d,
                          input logic zr, input logic ng);
      chk({tag, "_valid"}, {15'd0, bus.out_valid}, {15'd0, v});
      chk({tag, "_data"},  bus.out_data, d);
      chk({tag, "_zr"},    {15'd0, bus.out_zr}, {15'd0, zr});
      chk({tag, "_ng"},    {15'd0, bus.out_ng}, {15'd0, ng});
      $display("[%0t] %s valid=%b data=%h zr=%b ng=%b", $time, tag,
               bus.out_valid, bus.out_data, bus.out_zr, bus.out_ng);
   endtask

   initial begin
      logic [15:0] q[$];
      logic [15:0] prev_data;
      logic        prev_stall;
      logic [15:0] exp_word;

      assert_cnt = 0;
      fail_cnt   = 0;
      prev_data  = 16'h0000;
      prev_stall = 1'b0;

      // Reset with junk on the input
      reset         = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'hFFFF;
      bus.out_ready = 1'b0;
`ifdef OR16_STAGE_ACCUM_EN
      bus.acc_en    = 1'b0;
`endif
      step();
      step();
      chk_out("reset", 1'b0, 16'h0000, 1'b0, 1'b0);
      chk("reset_in_ready", {15'd0, bus.in_ready}, 16'd1);

      // Streaming
      reset         = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'h0001;
      step();
      chk_out("stream0", 1'b1, 16'h0001, 1'b0, 1'b0);
      bus.in_data = 16'h8000;
      step();
      chk_out("stream1", 1'b1, 16'h8000, 1'b0, 1'b1);
      bus.in_data = 16'h0000;
      step();
      chk_out("stream2", 1'b1, 16'h0000, 1'b1, 1'b0);
      chk("stream_in_ready", {15'd0, bus.in_ready}, 16'd1);
      bus.in_valid = 1'b0;
      step();
      chk("stream_drained", {15'd0, bus.out_valid}, 16'd0);

      // Backpressure
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'h00A5;
      step();
      chk_out("bp_first", 1'b1, 16'h00A5, 1'b0, 1'b0);
      chk("bp_ready1", {15'd0, bus.in_ready}, 16'd1);
      bus.in_data = 16'h5A00;
      step();
      chk("bp_ready2", {15'd0, bus.in_ready}, 16'd0);
      chk("bp_hold2", bus.out_data, 16'h00A5);
      bus.in_data = 16'h1234;
      step();
      chk("bp_ready3", {15'd0, bus.in_ready}, 16'd0);
      chk("bp_hold3", bus.out_data, 16'h00A5);
      bus.out_ready = 1'b1;
      step();
      chk_out("bp_rel0", 1'b1, 16'h5A00, 1'b0, 1'b0);
      chk("bp_ready_rec", {15'd0, bus.in_ready}, 16'd1);
      step();
      chk_out("bp_rel1", 1'b1, 16'h1234, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      step();
      chk("bp_drained", {15'd0, bus.out_valid}, 16'd0);

      // Random stress against a FIFO model
      for (int c = 0; c < 1000; c++) begin
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.out_ready = 1'($urandom_range(0, 3) != 0);
         bus.in_data   = 16'($urandom);
         #1;
         if (prev_stall) chk("rand_stable", bus.out_data, prev_data);
         chk("rand_valid", {15'd0, bus.out_valid}, {15'd0, q.size() > 0});
         chk("rand_in_ready", {15'd0, bus.in_ready}, {15'd0, q.size() < 2});
         if (bus.out_valid && bus.out_ready && q.size() > 0) begin
            exp_word = q.pop_front();
            chk("rand_order", bus.out_data, exp_word);
            chk("rand_zr", {15'd0, bus.out_zr}, {15'd0, exp_word == 16'h0000});
            chk("rand_ng", {15'd0, bus.out_ng}, {15'd0, exp_word[15]});
            $display("[%0t] rand deliver %h", $time, bus.out_data);
         end
         if (bus.in_valid && bus.in_ready) q.push_back(bus.in_data);
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (bus.out_valid && q.size() > 0) begin
            exp_word = q.pop_front();
            chk("drain_order", bus.out_data, exp_word);
         end
         step();
      end
      chk("drain_empty", {15'd0, bus.out_valid}, 16'd0);
      chk("drain_model", 16'(q.size()), 16'd0);

      // Reset while FULL
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'hBEEF;
      step();
      bus.in_data = 16'hCAFE;
      step();
      chk("mid_full", {15'd0, bus.in_ready}, 16'd0);
      reset         = 1'b1;
      bus.out_ready = 1'b1;
      step();
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      chk_out("mid_reset", 1'b0, 16'h0000, 1'b0, 1'b0);
      chk("mid_in_ready", {15'd0, bus.in_ready}, 16'd1);
      step();
      step();
      chk("mid_no_stale", {15'd0, bus.out_valid}, 16'd0);

`ifdef OR16_STAGE_ACCUM_EN
      // OR-accumulate sequence
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'h0001;
      bus.acc_en    = 1'b0;
      step();
      chk_out("acc0", 1'b1, 16'h0001, 1'b0, 1'b0);
      bus.in_data = 16'h0100;
      bus.acc_en  = 1'b1;
      step();
      chk_out("acc1", 1'b1, 16'h0101, 1'b0, 1'b0);
      bus.in_data = 16'h8000;
      step();
      chk_out("acc2", 1'b1, 16'h8101, 1'b0, 1'b1);
      bus.in_data = 16'h0002;
      bus.acc_en  = 1'b0;
      step();
      chk_out("acc3", 1'b1, 16'h0002, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      step();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end
endmodule
